// File: rtl/daq_pkg.sv
// Shared state encodings and transfer-direction constants for the DAQ transfer sequencer.
// Latency: n/a. Backpressure: n/a.
package daq_pkg;

    localparam logic [7:0] S_IDLE      = 8'h00;
    localparam logic [7:0] S_START     = 8'h01;
    localparam logic [7:0] S_WAIT_ACT  = 8'h02;
    localparam logic [7:0] S_WAIT_DONE = 8'h03;
    localparam logic [7:0] S_DONE      = 8'h04;
    localparam logic [7:0] S_ERROR     = 8'h05;

    typedef enum logic [7:0] {
        ST_IDLE      = S_IDLE,
        ST_START     = S_START,
        ST_WAIT_ACT  = S_WAIT_ACT,
        ST_WAIT_DONE = S_WAIT_DONE,
        ST_DONE      = S_DONE,
        ST_ERROR     = S_ERROR
    } daq_state_e;

    localparam logic DAQ_DIR_READ  = 1'b0;
    localparam logic DAQ_DIR_WRITE = 1'b1;

endpackage

// File: rtl/daq_xfer_sm_if.sv
// Bus-master side of the transfer sequencer: start/active handshake with address and data.
// Latency: n/a. Backpressure: the master holds active high while the transaction is in flight.
interface daq_xfer_sm_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0]   address;
    logic            start;
    logic [dw/8-1:0] selection;
    logic            write;
    logic [dw-1:0]   data_wr;
    logic [dw-1:0]   data_rd;
    logic            active;

    modport master (
        output address, start, selection, write, data_wr,
        input  data_rd, active
    );

    modport slave (
        input  address, start, selection, write, data_wr,
        output data_rd, active
    );
endinterface

// File: rtl/daq_ch_ptr.sv
// Per-channel stream pointer file: rewind to zero, advance by one word with wrap, comb read port.
// Latency: read is combinational, updates land next cycle. Backpressure: none.
module daq_ch_ptr #(
    parameter int          NUM_CH    = 4,
    parameter int unsigned CH_STRIDE = 32'h1000,
    parameter int unsigned STEP      = 4,
    parameter int          CW        = 2,
    parameter int          PW        = 12
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          rew_en,
    input  logic [CW-1:0] rew_ch,
    input  logic          adv_en,
    input  logic [CW-1:0] adv_ch,
    input  logic [CW-1:0] rd_ch,
    output logic [PW-1:0] rd_ptr
);
    logic [PW-1:0] ptr_q [NUM_CH];
    logic [PW-1:0] ptr_d [NUM_CH];

    assign rd_ptr = ptr_q[rd_ch];

    // Rewind and advance never coincide: rewind is only honoured while idle.
    always_comb begin
        ptr_d = ptr_q;
        if (rew_en) begin
            ptr_d[rew_ch] = '0;
        end
        if (adv_en) begin
            ptr_d[adv_ch] = PW'((32'(ptr_q[adv_ch]) + STEP) & (CH_STRIDE - 32'd1));
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/daq_xfer_sm.sv
// Turns single-word file read/write requests into one bus-master transaction each, with timeout.
// Latency: 4 cycles request-to-done with a 1-cycle master. Backpressure: requests dropped while busy.
module daq_xfer_sm
    import daq_pkg::*;
#(
    parameter int          dw        = 32,
    parameter int          aw        = 32,
    parameter int          NUM_CH    = 4,
    parameter logic [aw-1:0] BASE_ADDR = '0,
    parameter int unsigned CH_STRIDE = 32'h1000,
    parameter int          TIMEOUT   = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [7:0]    file_num,
    input  logic          file_read,
    input  logic          file_write,
    input  logic          file_rewind,
    input  logic [dw-1:0] file_write_data,
    output logic [dw-1:0] file_read_data,
    output logic          file_busy,
    output logic          file_done,
    output logic          file_error,
    daq_xfer_sm_if.master bus
);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW   = (CH_STRIDE > 1) ? $clog2(CH_STRIDE) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam int BW   = dw / 8;

    daq_state_e      state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [aw-1:0]   address_q, address_d;
    logic            write_q, write_d;
    logic [dw-1:0]   data_wr_q, data_wr_d;
    logic [BW-1:0]   sel_q, sel_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [dw-1:0]   rdat_q, rdat_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            rew_en, adv_en, req, in_range, both;
    logic [CW-1:0]   ch_idx;
    logic [PW-1:0]   rd_ptr, offset;

    assign ch_idx   = file_num[CW-1:0];
    assign in_range = ({24'd0, file_num} < 32'(NUM_CH));
    assign req      = file_read | file_write;
    assign both     = file_read & file_write;

    daq_ch_ptr #(
        .NUM_CH(NUM_CH), .CH_STRIDE(CH_STRIDE), .STEP(BW), .CW(CW), .PW(PW)
    ) u_ptr (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .rew_en (rew_en),
        .rew_ch (ch_idx),
        .adv_en (adv_en),
        .adv_ch (ch_q),
        .rd_ch  (ch_idx),
        .rd_ptr (rd_ptr)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        address_d = address_q;
        write_d   = write_q;
        data_wr_d = data_wr_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        rdat_d    = rdat_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        rew_en    = 1'b0;
        adv_en    = 1'b0;
        offset    = rd_ptr;
        case (state_q)
            ST_IDLE: begin
                // A coinciding rewind zeroes the stored pointer and the offset of this access.
                rew_en = file_rewind & in_range & ~both;
                if (rew_en) begin
                    offset = '0;
                end
                if (req) begin
                    if (both || !in_range) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d   = ST_START;
                        ch_d      = ch_idx;
                        write_d   = file_write ? DAQ_DIR_WRITE : DAQ_DIR_READ;
                        address_d = BASE_ADDR + aw'(32'(ch_idx) * CH_STRIDE) + aw'(offset);
                        data_wr_d = file_write ? file_write_data : '0;
                        sel_d     = '1;
                        start_d   = 1'b1;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_ACT;
            end
            ST_WAIT_ACT, ST_WAIT_DONE: begin
                // Completion wins over a timeout landing on the same cycle.
                if (state_q == ST_WAIT_DONE && !bus.active) begin
                    if (write_q == DAQ_DIR_READ) begin
                        rdat_d = bus.data_rd;
                    end
                    adv_en  = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == ST_WAIT_ACT && bus.active) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                state_d   = ST_IDLE;
                address_d = '0;
                write_d   = 1'b0;
                data_wr_d = '0;
                sel_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            address_q <= '0;
            write_q   <= 1'b0;
            data_wr_q <= '0;
            sel_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rdat_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            address_q <= address_d;
            write_q   <= write_d;
            data_wr_q <= data_wr_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rdat_q    <= rdat_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.start      = start_q;
    assign bus.selection  = sel_q;
    assign bus.write      = write_q;
    assign bus.data_wr    = data_wr_q;
    assign file_read_data = rdat_q;
    assign file_busy      = busy_q;
    assign file_done      = done_q;
    assign file_error     = error_q;

`ifdef SIM
    logic [8*9-1:0] state_name;
    always_comb begin
        state_name = "UNKNOWN";
        case (state_q)
            ST_IDLE:      state_name = "IDLE";
            ST_START:     state_name = "START";
            ST_WAIT_ACT:  state_name = "WAIT_ACT";
            ST_WAIT_DONE: state_name = "WAIT_DONE";
            ST_DONE:      state_name = "DONE";
            ST_ERROR:     state_name = "ERROR";
            default:      state_name = "UNKNOWN";
        endcase
    end
`endif
endmodule
